// File: rtl/fltr_sched.sv
// Round-robin scheduler sharing one multiply-accumulate FIR core across NCH sample channels.
// Each grant shifts the sample into that channel's delay line, runs TAPS MAC cycles and emits a saturated result.
module fltr_sched #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned TAPS = 4,
   parameter int unsigned DW   = 16,
   parameter int unsigned CW   = 16,
   parameter int unsigned OW   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCH-1:0]           req_vld,
   input  logic [NCH*DW-1:0]        req_data,
   output logic [NCH-1:0]           req_rdy,
   input  logic                     cfg_we,
   input  logic [$clog2(TAPS)-1:0]  cfg_addr,
   input  logic [CW-1:0]            cfg_coef,
   output logic                     cfg_busy,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [$clog2(NCH)-1:0]   out_ch,
   output logic [OW-1:0]            out_data
);

   localparam int unsigned CHW = $clog2(NCH);
   localparam int unsigned KW  = $clog2(TAPS);
   localparam int unsigned PW  = DW + CW;
   localparam int unsigned AW  = PW + KW;
   localparam int unsigned SW  = (AW > OW) ? AW : OW;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   logic [1:0]             state_q, state_d;
   logic signed [DW-1:0]   dly_q  [NCH][TAPS];
   logic signed [DW-1:0]   dly_d  [NCH][TAPS];
   logic signed [CW-1:0]   coef_q [TAPS];
   logic signed [CW-1:0]   coef_d [TAPS];
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [KW-1:0]          tap_q, tap_d;
   logic [CHW-1:0]         last_q, last_d;
   logic [CHW-1:0]         ch_q, ch_d;
   logic                   vld_q, vld_d;
   logic [OW-1:0]          data_q, data_d;
   logic                   busy_q, busy_d;

   logic                   gnt_vld;
   logic [CHW-1:0]         gnt_ch;
   logic                   hs;
   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   acc_sum;
   logic signed [SW-1:0]   acc_ext;
   logic [OW-1:0]          acc_sat;

   // Round-robin search starting just after the last granted channel
   always_comb begin
      logic [CHW-1:0] idx;
      gnt_vld = 1'b0;
      gnt_ch  = last_q;
      idx     = '0;
      for (int unsigned n = 1; n <= NCH; n++) begin
         idx = CHW'((32'(last_q) + n) % NCH);
         if (!gnt_vld && req_vld[idx]) begin
            gnt_vld = 1'b1;
            gnt_ch  = idx;
         end
      end
   end

   assign hs      = (state_q == IDLE) && gnt_vld;
   assign req_rdy = hs ? (NCH'(1'b1) << gnt_ch) : '0;

   // Accumulator is wide enough that only the final value needs clamping
   assign prod    = coef_q[tap_q] * dly_q[ch_q][tap_q];
   assign acc_sum = acc_q + AW'(prod);
   assign acc_ext = SW'(acc_sum);
   assign acc_sat = (acc_ext > SAT_MAX) ? SAT_MAX[OW-1:0] :
                    (acc_ext < SAT_MIN) ? SAT_MIN[OW-1:0] : acc_ext[OW-1:0];

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      coef_d  = coef_q;
      acc_d   = acc_q;
      tap_d   = tap_q;
      last_d  = last_q;
      ch_d    = ch_q;
      vld_d   = vld_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (cfg_we && (32'(cfg_addr) < TAPS)) coef_d[cfg_addr] = cfg_coef;
            if (hs) begin
               for (int unsigned k = TAPS - 1; k > 0; k--) dly_d[gnt_ch][k] = dly_q[gnt_ch][k-1];
               dly_d[gnt_ch][0] = req_data[32'(gnt_ch)*DW +: DW];
               acc_d   = '0;
               tap_d   = '0;
               last_d  = gnt_ch;
               ch_d    = gnt_ch;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            tap_d = tap_q + KW'(1);
            if (tap_q == KW'(TAPS - 1)) begin
               state_d = OUT;
               vld_d   = 1'b1;
               data_d  = acc_sat;
            end
         end
         OUT: begin
            if (out_rdy) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         for (int unsigned c = 0; c < NCH; c++)
            for (int unsigned k = 0; k < TAPS; k++) dly_q[c][k] <= '0;
         for (int unsigned k = 0; k < TAPS; k++) coef_q[k] <= '0;
         acc_q   <= '0;
         tap_q   <= '0;
         last_q  <= CHW'(NCH - 1);
         ch_q    <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         coef_q  <= coef_d;
         acc_q   <= acc_d;
         tap_q   <= tap_d;
         last_q  <= last_d;
         ch_q    <= ch_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign cfg_busy = busy_q;
   assign out_vld  = vld_q;
   assign out_ch   = ch_q;
   assign out_data = data_q;

endmodule

// File: tb/tb_fltr_sched.sv
// Directed bench for fltr_sched: a cycle-level arbiter/FIR model pushes expected results at each grant
// and a scoreboard pops them at each output handshake.
module tb_fltr_sched;

   localparam int unsigned NCH  = 4;
   localparam int unsigned TAPS = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned CW   = 16;
   localparam int unsigned OW   = 32;
   localparam int unsigned CHW  = 2;
   localparam int unsigned KW   = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    req_vld = '0;
   logic [NCH*DW-1:0] req_data = '0;
   logic [NCH-1:0]    req_rdy;
   logic              cfg_we = 1'b0;
   logic [KW-1:0]     cfg_addr = '0;
   logic [CW-1:0]     cfg_coef = '0;
   logic              cfg_busy;
   logic              out_vld;
   logic              out_rdy = 1'b1;
   logic [CHW-1:0]    out_ch;
   logic [OW-1:0]     out_data;

   fltr_sched #(.NCH(NCH), .TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef), .cfg_busy(cfg_busy),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_ch(out_ch), .out_data(out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      logic [OW-1:0] data;
      int          t;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   longint        m_coef[TAPS];
   longint        m_dly[NCH][TAPS];
   int            m_last;
   bit            m_busy;
   int            gnt_ch_log[$];
   int            gnt_t_log[$];
   logic [OW-1:0] last_data;
   int            last_ch;
   int            last_out_t;
   logic          prev_vld, prev_hold;
   logic [OW-1:0] prev_data;
   logic [CHW-1:0] prev_ch;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [OW-1:0] sat(input longint s);
      longint hi = (longint'(1) <<< 31) - 1;
      longint lo = -(longint'(1) <<< 31);
      if (s > hi) return 32'h7FFF_FFFF;
      if (s < lo) return 32'h8000_0000;
      return s[OW-1:0];
   endfunction

   // One clock cycle: sample #1 after the falling edge, update model, advance to the next falling edge
   task automatic tick();
      logic [NCH-1:0] exp_rdy;
      bit             clr_busy;
      longint         s;
      exp_t           e;
      int             w;
      #1;
      clr_busy = 1'b0;
      chk("cfg_busy", 64'(cfg_busy), 64'(m_busy));
      if (prev_hold) begin
         chk("hold_vld", 64'(out_vld), 64'd1);
         chk("hold_data", 64'(out_data), 64'(prev_data));
         chk("hold_ch", 64'(out_ch), 64'(prev_ch));
      end
      if (out_vld && !prev_vld) begin
         if (sb.size() == 0) chk("spurious_out", 64'(out_vld), 64'd0);
         else begin
            chk("latency", 64'(cyc), 64'(sb[0].t));
            last_out_t = cyc;
         end
      end
      if (out_vld && out_rdy && sb.size() > 0) begin
         e = sb.pop_front();
         chk("out_ch", 64'(out_ch), 64'(e.ch));
         chk("out_data", 64'(out_data), 64'(e.data));
         last_data = out_data;
         last_ch   = int'(out_ch);
         clr_busy  = 1'b1;
      end
      exp_rdy = '0;
      if (!m_busy)
         for (int n = 1; n <= NCH; n++) begin
            w = (m_last + n) % NCH;
            if (req_vld[w] && exp_rdy == '0) exp_rdy[w] = 1'b1;
         end
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      if (cfg_we && !m_busy) m_coef[cfg_addr] = longint'($signed(cfg_coef));
      for (int i = 0; i < NCH; i++)
         if (exp_rdy[i]) begin
            for (int k = TAPS - 1; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
            m_dly[i][0] = longint'($signed(req_data[i*DW +: DW]));
            s = 0;
            for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_dly[i][k];
            e.ch = i; e.data = sat(s); e.t = cyc + TAPS + 1;
            sb.push_back(e);
            gnt_ch_log.push_back(i);
            gnt_t_log.push_back(cyc);
            m_last = i;
            m_busy = 1'b1;
         end
      if (clr_busy) m_busy = 1'b0;
      prev_vld  = out_vld;
      prev_hold = out_vld && !out_rdy;
      prev_data = out_data;
      prev_ch   = out_ch;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asserts reset immediately (async), checks reset outputs, releases on a falling edge
   task automatic do_reset();
      rst_n   = 1'b0;
      req_vld = '0;
      cfg_we  = 1'b0;
      out_rdy = 1'b1;
      #1;
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd0);
      chk("rst_cfg_busy", 64'(cfg_busy), 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      sb.delete();
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < TAPS; k++) m_dly[c][k] = 0;
      for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
      m_last    = NCH - 1;
      m_busy    = 1'b0;
      prev_vld  = 1'b0;
      prev_hold = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic cfg(input int a, input int v);
      cfg_we   = 1'b1;
      cfg_addr = KW'(a);
      cfg_coef = CW'(v);
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic send(input int ch, input int sample);
      int n0 = gnt_ch_log.size();
      int b  = 0;
      req_data[ch*DW +: DW] = DW'(sample);
      req_vld[ch] = 1'b1;
      while (gnt_ch_log.size() == n0 && b < 50) begin tick(); b++; end
      req_vld[ch] = 1'b0;
      if (gnt_ch_log.size() == n0) chk("grant_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int b = 0;
      while ((sb.size() > 0 || m_busy) && b < 100) begin tick(); b++; end
      if (sb.size() > 0 || m_busy) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_out();
      int b = 0;
      while (!out_vld && b < 20) begin tick(); b++; end
      chk("wait_out", 64'(out_vld), 64'd1);
   endtask

   task automatic scen1();
      int t0;
      send(0, 100);
      t0 = gnt_t_log[gnt_t_log.size()-1];
      drain();
      chk("s1_ch", 64'(last_ch), 64'd0);
      chk("s1_data", 64'(last_data), 64'd0);
      chk("s1_lat", 64'(last_out_t - t0), 64'(TAPS + 1));
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // zero coefficients, first result
      scen1();

      // two-tap filter, per-channel history
      do_reset();
      cfg(0, 1);
      cfg(1, 2);
      send(0, 10); drain(); chk("s2_a", 64'(last_data), 64'd10);
      send(0, 20); drain(); chk("s2_b", 64'(last_data), 64'd40);
      send(1, 5);  drain(); chk("s2_c", 64'(last_data), 64'd5);

      // all channels requesting continuously
      do_reset();
      gnt_ch_log.delete();
      gnt_t_log.delete();
      for (int i = 0; i < NCH; i++) req_data[i*DW +: DW] = DW'(i + 1);
      req_vld = '1;
      for (int b = 0; b < 60 && gnt_ch_log.size() < 6; b++) tick();
      req_vld = '0;
      drain();
      chk("s3_count", 64'(gnt_ch_log.size()), 64'd6);
      for (int j = 0; j < 6 && j < gnt_ch_log.size(); j++)
         chk("s3_order", 64'(gnt_ch_log[j]), 64'(j % NCH));
      for (int j = 1; j < 6 && j < gnt_t_log.size(); j++)
         chk("s3_gap", 64'(gnt_t_log[j] - gnt_t_log[j-1]), 64'(TAPS + 2));

      // saturation in both directions
      do_reset();
      for (int k = 0; k < TAPS; k++) cfg(k, -32768);
      repeat (4) begin send(2, -32768); drain(); end
      chk("s4_pos", 64'(last_data), 64'h7FFF_FFFF);
      for (int k = 0; k < TAPS; k++) cfg(k, 32767);
      send(2, -32768); drain();
      chk("s4_neg", 64'(last_data), 64'h8000_0000);

      // output stall: held output, blocked requester, dropped cfg write
      out_rdy = 1'b0;
      send(1, 3);
      wait_out();
      req_vld[0] = 1'b1;
      tick();
      tick();
      cfg(0, 7);
      tick();
      tick();
      req_vld[0] = 1'b0;
      out_rdy = 1'b1;
      drain();
      chk("s5_data", 64'(last_data), 64'd98301);
      send(1, 1); drain();
      chk("s5_coef", 64'(last_data), 64'd131068);

      // reset while result is presented
      out_rdy = 1'b0;
      send(2, 9);
      wait_out();
      #2;
      do_reset();

      // reset during MAC, then a clean repeat of the first scenario
      send(0, 100);
      #2;
      do_reset();
      repeat (8) tick();
      scen1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
